// File: rtl/lemming_ctrl.sv
// Lemming behaviour controller: a Moore FSM for walking, falling, digging and splatting.
// Optional macro LEMMING_DIG_EN enables the DL/DR digging states; without it, dig is ignored.
module lemming_ctrl #(
  parameter int FALL_LIMIT  = 20,
  parameter bit START_RIGHT = 1'b0
) (
  input  logic clk,
  input  logic areset,
  input  logic bump_left,
  input  logic bump_right,
  input  logic ground,
  input  logic dig,
  output logic walk_left,
  output logic walk_right,
  output logic aaah,
  output logic digging,
  output logic splat
);

  localparam int CW = $clog2(FALL_LIMIT + 2);
  localparam logic [CW-1:0] LIMIT_C = CW'(FALL_LIMIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(FALL_LIMIT + 1);

  localparam logic [2:0] WL    = 3'd0;
  localparam logic [2:0] WR    = 3'd1;
  localparam logic [2:0] FL    = 3'd2;
  localparam logic [2:0] FR    = 3'd3;
  localparam logic [2:0] SPLAT = 3'd4;
`ifdef LEMMING_DIG_EN
  localparam logic [2:0] DL    = 3'd5;
  localparam logic [2:0] DR    = 3'd6;
`endif
  localparam logic [2:0] RST_STATE = START_RIGHT ? WR : WL;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] fall_cnt_q, fall_cnt_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      WL: begin
        if (!ground) state_d = FL;
`ifdef LEMMING_DIG_EN
        else if (dig) state_d = DL;
`endif
        else if (bump_left) state_d = WR;
      end
      WR: begin
        if (!ground) state_d = FR;
`ifdef LEMMING_DIG_EN
        else if (dig) state_d = DR;
`endif
        else if (bump_right) state_d = WL;
      end
      // fall_cnt_q already includes the current falling cycle
      FL: if (ground) state_d = (fall_cnt_q > LIMIT_C) ? SPLAT : WL;
      FR: if (ground) state_d = (fall_cnt_q > LIMIT_C) ? SPLAT : WR;
`ifdef LEMMING_DIG_EN
      DL: if (!ground) state_d = FL;
      DR: if (!ground) state_d = FR;
`endif
      SPLAT: state_d = SPLAT;
      default: state_d = RST_STATE;
    endcase
  end

  always_comb begin
    fall_cnt_d = '0;
    if (state_d == FL || state_d == FR) begin
      if (state_q == FL || state_q == FR)
        fall_cnt_d = (fall_cnt_q == CNT_MAX) ? fall_cnt_q : fall_cnt_q + 1'b1;
      else
        fall_cnt_d = CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q    <= RST_STATE;
      fall_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      fall_cnt_q <= fall_cnt_d;
    end
  end

  assign walk_left  = (state_q == WL);
  assign walk_right = (state_q == WR);
  assign aaah       = (state_q == FL) || (state_q == FR);
  assign splat      = (state_q == SPLAT);
`ifdef LEMMING_DIG_EN
  assign digging    = (state_q == DL) || (state_q == DR);
`else
  logic unused_dig;
  assign unused_dig = dig;
  assign digging    = 1'b0;
`endif

endmodule

// File: tb/tb_lemming_ctrl.sv
// Scoreboard testbench for lemming_ctrl: directed vectors push expected outputs, a monitor compares.
// Expectations follow LEMMING_DIG_EN so the same bench covers both builds.
module tb_lemming_ctrl;

   localparam logic [4:0] E_WL = 5'b10000;
   localparam logic [4:0] E_WR = 5'b01000;
   localparam logic [4:0] E_FA = 5'b00100;
   localparam logic [4:0] E_DG = 5'b00010;
   localparam logic [4:0] E_SP = 5'b00001;

   typedef struct {
      logic [4:0] exp;
      int         due;
      string      name;
   } sb_item_t;

   logic clk = 1'b0;
   logic areset, bump_left, bump_right, ground, dig;
   logic walk_left, walk_right, aaah, digging, splat;

   sb_item_t scoreboard[$];
   int cyc = 0;
   int vectorCount = 0;
   int failCount = 0;

   lemming_ctrl #(.FALL_LIMIT(20), .START_RIGHT(1'b0)) dut (
      .clk(clk),
      .areset(areset),
      .bump_left(bump_left),
      .bump_right(bump_right),
      .ground(ground),
      .dig(dig),
      .walk_left(walk_left),
      .walk_right(walk_right),
      .aaah(aaah),
      .digging(digging),
      .splat(splat)
   );

   // Free-running clock and a cycle counter used to time-stamp scoreboard entries
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Drives one cycle of inputs at the falling edge and queues the output expected after the next rising edge
   task automatic applyStimulus(input logic rst, input logic bl, input logic br,
                                input logic gnd, input logic dg,
                                input logic [4:0] exp, input string name);
      sb_item_t item;
      @(negedge clk);
      areset     = rst;
      bump_left  = bl;
      bump_right = br;
      ground     = gnd;
      dig        = dg;
      item.exp  = exp;
      item.due  = cyc + 1;
      item.name = name;
      scoreboard.push_back(item);
   endtask

   // Compares one scoreboard entry against the live DUT outputs
   task automatic checkOutput(input sb_item_t item);
      logic [4:0] act;
      act = {walk_left, walk_right, aaah, digging, splat};
      vectorCount++;
      if (act !== item.exp) begin
         failCount++;
         $display("[TB] FAIL %s (cycle %0d): got %b, expected %b (wl,wr,aaah,dig,splat)",
                  item.name, cyc, act, item.exp);
      end
   endtask

   // Monitor: a few time units after each rising edge, retire every entry that has come due
   initial begin
      forever begin
         @(posedge clk);
         #3;
         while (scoreboard.size() > 0 && scoreboard[0].due <= cyc)
            checkOutput(scoreboard.pop_front());
      end
   end

   initial begin
      areset = 1'b1; bump_left = 1'b0; bump_right = 1'b0; ground = 1'b1; dig = 1'b0;

      // Reset state and facing-side bump behaviour
      applyStimulus(1, 0, 0, 1, 0, E_WL, "reset_state");
      applyStimulus(0, 1, 0, 1, 0, E_WR, "bump_left_turns");
      applyStimulus(0, 1, 0, 1, 0, E_WR, "bump_left_ignored_in_wr");
      applyStimulus(0, 0, 0, 1, 0, E_WR, "idle_wr");

      // Survivable 20-cycle fall to the right, with bumps ignored mid-fall
      for (int i = 0; i < 20; i++)
         applyStimulus(0, (i % 3 == 0), 0, 0, 0, E_FA, "fall20_aaah");
      applyStimulus(0, 0, 0, 1, 0, E_WR, "fall20_lands_wr");

      // Bump handling in WL including simultaneous bumps
      applyStimulus(0, 0, 1, 1, 0, E_WL, "bump_right_turns");
      applyStimulus(0, 0, 1, 1, 0, E_WL, "bump_right_ignored_in_wl");
      applyStimulus(0, 1, 1, 1, 0, E_WR, "both_bumps_reverse_1");
      applyStimulus(0, 1, 1, 1, 0, E_WL, "both_bumps_reverse_2");

      // Shortest possible fall
      applyStimulus(0, 0, 0, 0, 0, E_FA, "fall1_aaah");
      applyStimulus(0, 0, 0, 1, 0, E_WL, "fall1_lands_wl");

      // Fatal 21-cycle fall, absorbing SPLAT, then reset out of it
      for (int i = 0; i < 21; i++)
         applyStimulus(0, 0, 0, 0, 0, E_FA, "fall21_aaah");
      applyStimulus(0, 0, 0, 1, 0, E_SP, "fall21_splat");
      for (int i = 0; i < 50; i++)
         applyStimulus(0, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), E_SP, "splat_held");
      applyStimulus(1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), E_WL, "reset_from_splat");
      applyStimulus(0, 0, 0, 1, 0, E_WL, "idle_after_splat_reset");

`ifdef LEMMING_DIG_EN
      // Dig beats bump, digging ignores dig/bumps, and a dig ends in a fall
      applyStimulus(0, 1, 0, 1, 1, E_DG, "dig_beats_bump");
      applyStimulus(0, 1, 1, 1, 1, E_DG, "digging_ignores_bumps");
      applyStimulus(0, 0, 0, 0, 0, E_FA, "dig_fall_left");
      applyStimulus(0, 0, 0, 1, 0, E_WL, "dig_fall_lands_wl");
      applyStimulus(0, 1, 0, 1, 0, E_WR, "turn_for_dig_right");
      applyStimulus(0, 0, 0, 1, 1, E_DG, "dig_right");
      applyStimulus(0, 1, 1, 1, 0, E_DG, "dig_right_ignores_bumps");
      applyStimulus(0, 0, 0, 0, 0, E_FA, "dig_fall_right");
      applyStimulus(0, 0, 0, 1, 0, E_WR, "dig_fall_lands_wr");
      applyStimulus(0, 0, 1, 1, 0, E_WL, "back_to_wl");
`else
      // With digging compiled out, dig is ignored and bump_left still turns
      applyStimulus(0, 1, 0, 1, 1, E_WR, "nodig_bump_turns");
      applyStimulus(0, 0, 0, 1, 1, E_WR, "nodig_dig_ignored");
      applyStimulus(0, 0, 1, 1, 0, E_WL, "nodig_back_to_wl");
      applyStimulus(0, 0, 0, 0, 1, E_FA, "nodig_fall");
      applyStimulus(0, 0, 0, 1, 0, E_WL, "nodig_fall_lands_wl");
`endif

      // Fall beats dig; reset mid-fall clears the fall counter
      applyStimulus(0, 1, 0, 1, 0, E_WR, "turn_for_reset_fall");
      applyStimulus(0, 0, 0, 0, 1, E_FA, "fall_beats_dig");
      for (int i = 0; i < 9; i++)
         applyStimulus(0, 0, 0, 0, 0, E_FA, "pre_reset_fall");
      applyStimulus(1, 0, 0, 0, 0, E_WL, "reset_mid_fall");
      for (int i = 0; i < 20; i++)
         applyStimulus(0, 0, 0, 0, 0, E_FA, "post_reset_fall_aaah");
      applyStimulus(0, 0, 0, 1, 0, E_WL, "post_reset_fall_survives");

      // Let the monitor drain, then treat anything left over as a failure
      repeat (3) @(posedge clk);
      #5;
      if (scoreboard.size() != 0) begin
         failCount++;
         $display("[TB] FAIL scoreboard_drain: got %0d pending entries, expected 0", scoreboard.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, failCount);
      $finish;
   end

endmodule
